lcd_i2c_master: RTL and testbench

Hardware I2C byte engine for the LCD/touch-panel I2C bus on the Cyclone III starter board. It replaces software bit-banging of the LCD I2C data and clock PIO lines. The block is an Avalon-MM slave on the Nios II system bus. It generates START and STOP conditions and shifts one byte out or in per command, and it samples or drives the ACK bit. SDA and SCL are emulated open-drain: each is driven low or released to Z, with external pull-ups.

---
 rtl/lcd_i2c_master.sv | 179 +++++++++++++++++
 tb/tb_lcd_i2c_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_i2c_master.sv
// Avalon-MM I2C byte engine for the LCD bus: START, one byte WR or RD with ACK, STOP; SDA/SCL open-drain.
// Define LCD_I2C_CLK_STRETCH_EN to let a slave stretch SCL low during the high quarters.
module lcd_i2c_master #(
  parameter logic [15:0] DIV_RESET = 16'd124
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire         sda,
  inout  wire         scl
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  state_t      state;
  logic [1:0]  q;
  logic [2:0]  bit_idx;
  logic [15:0] clkdiv, div_act, qcnt;
  logic [7:0]  txdata, rxdata, shreg;
  logic        do_stop, do_wr, do_rd, nack;
  logic        sda_low, scl_low, rx_nack, done;
  logic        busy, cmd_acc, hold, tick;
  logic        unused;

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  assign busy    = (state != IDLE);
  assign cmd_acc = chipselect && !write_n && (address == 2'd1) && !busy && (|writedata[3:0]);

`ifdef LCD_I2C_CLK_STRETCH_EN
  // Freeze while the bus shows SCL low in a quarter where we have released it.
  assign hold = !scl && ((((state == BIT) || (state == ACK)) && q[1]) ||
                         (((state == START) || (state == STOP)) && ((q == 2'd1) || (q == 2'd2))));
  assign unused = ^writedata[31:16];
`else
  assign hold = 1'b0;
  assign unused = ^{writedata[31:16], scl};
`endif

  assign tick = (state != IDLE) && (state != DONE) && !hold && (qcnt == div_act);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txdata   <= 8'd0;
      clkdiv   <= DIV_RESET;
      readdata <= 32'd0;
    end else begin
      if (chipselect && !write_n) begin
        if (address == 2'd0) txdata <= writedata[7:0];
        if (address == 2'd3) clkdiv <= writedata[15:0];
      end
      if (chipselect) begin
        case (address)
          2'd0: readdata <= {24'd0, rxdata};
          2'd1: readdata <= 32'd0;
          2'd2: readdata <= {29'd0, done, rx_nack, busy};
          2'd3: readdata <= {16'd0, clkdiv};
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      q       <= 2'd0;
      bit_idx <= 3'd0;
      qcnt    <= 16'd0;
      div_act <= DIV_RESET;
      shreg   <= 8'd0;
      rxdata  <= 8'd0;
      do_stop <= 1'b0;
      do_wr   <= 1'b0;
      do_rd   <= 1'b0;
      nack    <= 1'b0;
      sda_low <= 1'b0;
      scl_low <= 1'b0;
      rx_nack <= 1'b0;
      done    <= 1'b0;
    end else begin
      if ((state == IDLE) || tick) qcnt <= 16'd0;
      else if (!hold)              qcnt <= qcnt + 16'd1;

      case (state)
        IDLE: if (cmd_acc) begin
          done    <= 1'b0;
          div_act <= clkdiv;
          shreg   <= txdata;
          do_stop <= writedata[1];
          do_wr   <= writedata[2];
          do_rd   <= writedata[3] & ~writedata[2];
          nack    <= writedata[4];
          q       <= 2'd0;
          bit_idx <= 3'd7;
          if (writedata[0]) begin
            state   <= START;
            sda_low <= 1'b0;
          end else if (writedata[2] | writedata[3]) begin
            state   <= BIT;
            scl_low <= 1'b1;
            sda_low <= writedata[2] & ~txdata[7];
          end else begin
            state   <= STOP;
            sda_low <= 1'b1;
            scl_low <= 1'b1;
          end
        end
        START: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: scl_low <= 1'b0;
            2'd1: sda_low <= 1'b1;
            2'd2: scl_low <= 1'b1;
            default: begin
              if (do_wr | do_rd) begin
                state   <= BIT;
                sda_low <= do_wr & ~shreg[7];
              end else if (do_stop) state <= STOP;
              else                  state <= DONE;
            end
          endcase
        end
        BIT: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd1: scl_low <= 1'b0;
            2'd2: shreg   <= {shreg[6:0], sda};
            2'd3: begin
              scl_low <= 1'b1;
              if (bit_idx == 3'd0) begin
                state   <= ACK;
                rxdata  <= shreg;
                sda_low <= do_rd & ~nack;
              end else begin
                bit_idx <= bit_idx - 3'd1;
                sda_low <= do_wr & ~shreg[7];
              end
            end
            default: ;
          endcase
        end
        ACK: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd1: scl_low <= 1'b0;
            2'd2: if (do_wr) rx_nack <= sda;
            2'd3: begin
              // Without STOP the clock stays low so the bus remains ours.
              scl_low <= 1'b1;
              sda_low <= do_stop;
              state   <= do_stop ? STOP : DONE;
            end
            default: ;
          endcase
        end
        STOP: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: scl_low <= 1'b0;
            2'd1: sda_low <= 1'b0;
            default: begin
              state <= DONE;
              q     <= 2'd0;
            end
          endcase
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_i2c_master.sv
// Bench for lcd_i2c_master: vector table plus hand sequences, with an I2C slave model and byte scoreboard.
module tb_lcd_i2c_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  wire         sda_w, scl_w;
  logic        sl_sda_low = 1'b0, sl_scl_low = 1'b0;

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = sl_sda_low ? 1'b0 : 1'bz;
  assign scl_w = sl_scl_low ? 1'b0 : 1'bz;

  lcd_i2c_master #(.DIV_RESET(16'd124)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .sda(sda_w), .scl(scl_w));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model and scoreboard ----------------
  int          cyc = 0;
  int          mode = 0;            // 0 write+ACK, 1 write+NACK, 2 read
  logic [7:0]  sl_tx = 8'd0, sl_rx = 8'd0;
  int          sl_cnt = 0, n_start = 0, n_stop = 0, n_rise = 0, last_rise = 0;
  int          rise_t[16];
  int          hi_len[16];
  logic        ack_bit = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, s_now, d_now;
  logic [7:0]  wexp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    s_now = scl_w;
    d_now = sda_w;
    if (prev_scl && s_now && prev_sda && !d_now) begin n_start++; sl_cnt = 0; end
    if (prev_scl && s_now && !prev_sda && d_now) n_stop++;
    if (!prev_scl && s_now) begin
      if (n_rise < 16) rise_t[n_rise] = cyc;
      n_rise++;
      last_rise = cyc;
      if (sl_cnt < 8) sl_rx = {sl_rx[6:0], d_now};
      else if (sl_cnt == 8) ack_bit = d_now;
      sl_cnt++;
      if (sl_cnt == 8 && mode != 2) begin
        if (wexp_q.size() == 0) check("sb_unexpected_byte", {24'd0, sl_rx}, 32'hFFFF_FFFF);
        else check("sb_byte", {24'd0, sl_rx}, {24'd0, wexp_q.pop_front()});
      end
    end
    if (prev_scl && !s_now) begin
      if (n_rise >= 1 && n_rise <= 16) hi_len[n_rise-1] = cyc - last_rise;
      if (mode == 2 && sl_cnt < 8)       sl_sda_low = ~sl_tx[7-sl_cnt];
      else if (mode == 0 && sl_cnt == 8) sl_sda_low = 1'b1;
      else                               sl_sda_low = 1'b0;
    end
    prev_scl = s_now;
    prev_sda = d_now;
  end

  // ---------------- bus tasks ----------------
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata; chipselect = 1'b0;
  endtask

  // Issue a CMD and poll STATUS every clk; n counts clks from the accepting edge to done visible on readdata.
  task automatic run_cmd(input logic [31:0] cmd, output int n, output logic first_busy, output logic [31:0] st);
    @(posedge clk); #1;
    address = 2'd1; writedata = cmd; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    write_n = 1'b1; address = 2'd2;
    n = 0; st = 32'd0; first_busy = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      st = readdata;
      if (n == 1) first_busy = st[0];
    end while (!st[2] && n < 20000);
    chipselect = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] st);
    int k;
    k = 0;
    do begin bus_rd(2'd2, st); k++; end while (!st[2] && k < 5000);
  endtask

  typedef struct {
    int          mode;
    logic [15:0] div;
    logic [7:0]  data;
    logic [7:0]  cmd;
    logic [7:0]  sbyte;
    logic [31:0] exp_status;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t        vecs[6];
  int          n, quarters;
  logic        fb;
  logic [31:0] st, rd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'd3, 8'hA5, 8'h07, 8'h00, 32'h4, 8'hA5};
    vecs[1] = '{1, 16'd3, 8'hA5, 8'h07, 8'h00, 32'h6, 8'hA5};
    vecs[2] = '{2, 16'd3, 8'h00, 8'h1B, 8'h3C, 32'h6, 8'h3C};  // rx_nack kept from the previous WR
    vecs[3] = '{0, 16'd0, 8'h5A, 8'h07, 8'h00, 32'h4, 8'h5A};
    vecs[4] = '{2, 16'd1, 8'h00, 8'h0B, 8'hC3, 32'h4, 8'hC3};
    vecs[5] = '{0, 16'd2, 8'h81, 8'h0F, 8'h00, 32'h4, 8'h81};  // WR wins over RD

    // Reset, then reset again while idle with a non-default CLKDIV
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus_wr(2'd3, 32'd5);
    bus_rd(2'd3, rd);
    check("clkdiv_write", rd, 32'd5);
    #3 reset = 1'b1;
    #1;
    check("rst_sda", {31'd0, sda_w}, 32'd1);
    check("rst_scl", {31'd0, scl_w}, 32'd1);
    check("rst_readdata", readdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    bus_rd(2'd2, rd); check("rst_status", rd, 32'd0);
    bus_rd(2'd3, rd); check("rst_clkdiv", rd, 32'd124);
    bus_rd(2'd0, rd); check("rst_rxdata", rd, 32'd0);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      mode = v.mode;
      sl_tx = v.sbyte;
      bus_wr(2'd3, {16'd0, v.div});
      bus_wr(2'd0, {24'd0, v.data});
      n_start = 0; n_stop = 0; n_rise = 0;
      if (v.mode != 2) wexp_q.push_back(v.exp_byte);
      run_cmd({24'd0, v.cmd}, n, fb, st);
      quarters = (v.cmd[0] ? 4 : 0) + ((v.cmd[2] | v.cmd[3]) ? 36 : 0) + (v.cmd[1] ? 3 : 0);
      check($sformatf("v%0d_busy_first", i), {31'd0, fb}, 32'd1);
      check($sformatf("v%0d_cycles", i), n, quarters * (v.div + 1) + 2);
      check($sformatf("v%0d_status", i), st, v.exp_status);
      check($sformatf("v%0d_scl_rises", i), n_rise, 9 + (v.cmd[1] ? 1 : 0));
      check($sformatf("v%0d_scl_period", i), rise_t[1] - rise_t[0], 4 * (v.div + 1));
      check($sformatf("v%0d_scl_high", i), hi_len[0], 2 * (v.div + 1));
      check($sformatf("v%0d_starts", i), n_start, {31'd0, v.cmd[0]});
      check($sformatf("v%0d_stops", i), n_stop, {31'd0, v.cmd[1]});
      check($sformatf("v%0d_idle_lines", i), {30'd0, sda_w, scl_w}, 32'd3);
      if (v.mode == 2) begin
        bus_rd(2'd0, rd);
        check($sformatf("v%0d_rxdata", i), rd, {24'd0, v.exp_byte});
        check($sformatf("v%0d_master_ack", i), {31'd0, ack_bit}, {31'd0, v.cmd[4]});
      end else begin
        check($sformatf("v%0d_sb_drained", i), wexp_q.size(), 0);
      end
    end

    // START+WR without STOP holds SCL low; a STOP-only command then frees the bus
    mode = 0;
    bus_wr(2'd3, 32'd3);
    bus_wr(2'd0, 32'h3C);
    wexp_q.push_back(8'h3C);
    n_start = 0; n_stop = 0; n_rise = 0;
    run_cmd(32'h05, n, fb, st);
    check("hold_status", st, 32'h4);
    check("hold_scl_low", {31'd0, scl_w}, 32'd0);
    check("hold_stops", n_stop, 0);
    run_cmd(32'h02, n, fb, st);
    check("stoponly_cycles", n, 3 * 4 + 2);
    check("stoponly_lines", {30'd0, sda_w, scl_w}, 32'd3);
    check("stoponly_stops", n_stop, 1);

    // Second CMD while busy must be ignored
    bus_wr(2'd0, 32'hA5);
    wexp_q.push_back(8'hA5);
    n_start = 0; n_stop = 0; n_rise = 0;
    bus_wr(2'd1, 32'h07);
    repeat (8) @(posedge clk);
    bus_wr(2'd1, 32'h08);
    wait_done(st);
    check("busy_status", st, 32'h4);
    repeat (100) @(posedge clk);
    bus_rd(2'd2, rd);
    check("busy_status_later", rd, 32'h4);
    check("busy_scl_rises", n_rise, 10);
    check("busy_starts", n_start, 1);
    check("busy_stops", n_stop, 1);
    check("busy_sb_drained", wexp_q.size(), 0);

`ifdef LCD_I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 50 clk at the start of bit 3's high phase
    wexp_q.push_back(8'hA5);
    n_start = 0; n_stop = 0; n_rise = 0;
    fork
      run_cmd(32'h07, n, fb, st);
      begin : stretch
        int k;
        k = 0;
        while (!(n_rise == 3 && scl_w == 1'b0) && k < 2000) begin @(posedge clk); #1; k++; end
        sl_scl_low = 1'b1;
        repeat (8) @(posedge clk);
        repeat (50) @(posedge clk);
        #1 sl_scl_low = 1'b0;
      end
    join
    check("stretch_cycles", n, 43 * 4 + 2 + 50);
    check("stretch_high_len", hi_len[3], 8);
    check("stretch_status", st, 32'h4);
`endif

    // Reset in the middle of a command releases both lines at once
    mode = 0;
    bus_wr(2'd3, 32'd3);
    bus_wr(2'd0, 32'hA5);
    bus_wr(2'd1, 32'h07);
    repeat (18) @(posedge clk);
    #2;
    check("midrst_scl_before", {31'd0, scl_w}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_lines", {30'd0, sda_w, scl_w}, 32'd3);
    @(posedge clk); #1 reset = 1'b0;
    bus_rd(2'd2, rd);
    check("midrst_status", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
